// File: rtl/mem_responder.sv
// mem_responder: word-addressed data storage serving load/store requests.
// Stores are posted. Load data is queued in an in-order response FIFO so the
// consumer can stall the response channel without any loads being lost.
module mem_responder #(
  parameter int LEN_REG    = 32,
  parameter int MEM_ADDR   = 16,
  parameter int RESP_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_w,
  input  logic [MEM_ADDR-1:0]           req_addr,
  input  logic [LEN_REG-1:0]            req_data,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [LEN_REG-1:0]            resp_data,
  output logic [$clog2(RESP_DEPTH):0]   resp_count
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(RESP_DEPTH);

  // Storage is never reset; contents survive rst_n.
  logic [LEN_REG-1:0] mem  [2**MEM_ADDR];
  logic [LEN_REG-1:0] fifo [RESP_DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          pop, accept, push, store;

  // A pop frees a slot on the same edge, so a full FIFO can still take a
  // request while it drains. req_ready never depends on req_valid.
  assign resp_valid = (count != '0);
  assign pop        = resp_valid && resp_ready;
  assign req_ready  = (count < DEPTH) || pop;
  assign accept     = req_valid && req_ready;
  assign push       = accept && !req_w;
  assign store      = accept && req_w;
  assign resp_count = count;
  assign resp_data  = resp_valid ? fifo[head] : '0;

  // Posted store write; only one request per edge, so no read/write clash.
  always_ff @(posedge clk) begin
    if (store) mem[req_addr] <= req_data;
  end

  // Capture the pre-edge storage value into the FIFO tail on a load.
  always_ff @(posedge clk) begin
    if (push) fifo[tail] <= mem[req_addr];
  end

  // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: the stimulus process pushes expected
// load data, a negedge monitor pops and compares on every response handshake.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_w, resp_ready;
  logic        req_ready, resp_valid;
  logic [15:0] req_addr;
  logic [31:0] req_data, resp_data;
  logic [1:0]  resp_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  mem_responder #(.LEN_REG(32), .MEM_ADDR(16), .RESP_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_w(req_w),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_count(resp_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL resp_unexpected: got 0x%08h want no response", resp_data);
      end else begin
        check("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  // Present a request and hold it until accepted; returns the stall cycles.
  task automatic issue(input logic w, input logic [15:0] a, input logic [31:0] d,
                       input logic [31:0] exp, output int stalls);
    logic ok;
    int   n;
    req_valid = 1'b1; req_w = w; req_addr = a; req_data = d;
    if (!w) exp_q.push_back(exp);
    n = 0;
    do begin
      @(negedge clk);
      ok = req_ready;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) check("req_accept_timeout", 32'd0, 32'd1);
    stalls = n - 1;
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int s;
    rst_n = 1'b0; req_valid = 1'b0; req_w = 1'b0; req_addr = '0; req_data = '0;
    resp_ready = 1'b0;
    #12;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_count", resp_count, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: store then load, one-cycle latency
    resp_ready = 1'b1;
    issue(1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, s);
    issue(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, s);
    check("t1_valid_latency", resp_valid, 1);
    check("t1_count_after_push", resp_count, 1);
    check("t1_data_direct", resp_data, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("t1_count_after_pop", resp_count, 0);

    // 2: back-to-back at full throughput, includes the top address
    issue(1'b1, 16'h0000, 32'h11111111, 32'h0, s); check("t2_st0_stall", s, 0);
    issue(1'b1, 16'hFFFF, 32'h22222222, 32'h0, s); check("t2_st1_stall", s, 0);
    issue(1'b0, 16'hFFFF, 32'h0, 32'h22222222, s); check("t2_ld0_stall", s, 0);
    issue(1'b0, 16'h0000, 32'h0, 32'h11111111, s); check("t2_ld1_stall", s, 0);
    drain("t2_drain");

    // 3: backpressure, third load joins on the first pop edge
    resp_ready = 1'b0;
    issue(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, s);
    issue(1'b0, 16'hFFFF, 32'h0, 32'h22222222, s);
    check("t3_full_count", resp_count, 2);
    check("t3_full_ready", req_ready, 0);
    fork
      issue(1'b0, 16'h0000, 32'h0, 32'h11111111, s);
      begin
        @(posedge clk); #2;
        check("t3_held_ready", req_ready, 0);
        check("t3_held_count", resp_count, 2);
        resp_ready = 1'b1;
      end
    join
    check("t3_push_pop_count", resp_count, 2);
    drain("t3_drain");

    // 4: store blocked while full; loads queued before it see old value
    issue(1'b1, 16'h0020, 32'h12345678, 32'h0, s);
    resp_ready = 1'b0;
    issue(1'b0, 16'h0020, 32'h0, 32'h12345678, s);
    issue(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, s);
    fork
      issue(1'b1, 16'h0020, 32'hCAFEF00D, 32'h0, s);
      begin
        @(posedge clk); #2;
        check("t4_store_held", req_ready, 0);
        @(posedge clk); #2;
        check("t4_store_held_count", resp_count, 2);
        resp_ready = 1'b1;
      end
    join
    check("t4_count_after_store", resp_count, 1);
    issue(1'b0, 16'h0020, 32'h0, 32'hCAFEF00D, s);
    drain("t4_drain");

    // 5: read-after-write at minimum spacing
    issue(1'b1, 16'h0100, 32'hA5A5A5A5, 32'h0, s);
    issue(1'b0, 16'h0100, 32'h0, 32'hA5A5A5A5, s); check("t5_ld_before_stall", s, 0);
    issue(1'b1, 16'h0100, 32'h00000005, 32'h0, s); check("t5_st_stall", s, 0);
    issue(1'b0, 16'h0100, 32'h0, 32'h00000005, s); check("t5_ld_after_stall", s, 0);
    drain("t5_drain");

    // 6: asynchronous reset with two queued responses
    resp_ready = 1'b0;
    issue(1'b0, 16'h0100, 32'h0, 32'h00000005, s);
    issue(1'b0, 16'hFFFF, 32'h0, 32'h22222222, s);
    check("t6_pre_count", resp_count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", resp_valid, 0);
    check("t6_rst_count", resp_count, 0);
    check("t6_rst_data", resp_data, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    issue(1'b0, 16'h0100, 32'h0, 32'h00000005, s);
    check("t6_post_valid", resp_valid, 1);
    drain("t6_drain");

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
